// File: rtl/if_id_reg.sv
// IF/ID pipeline register for a fetch path whose instruction memory has a
// one-cycle read. It re-pairs each PC with its data, absorbs stalls and squashes on flush.
//
// state  | meaning
// RUN    | output stage takes inst_in directly
// REPLAY | stalled; hold_buf has the instruction that arrived on the first stall edge
module if_id_reg #(
  parameter int INST_MEMORY_SIZE = 16384,
  parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [63:0] pc_out,
  output logic [63:0] pc_plus4_out,
  output logic [31:0] inst_out,
  output logic        valid_out,
  output logic        misaligned_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 64) begin : g_bad_addr_width
    $error("if_id_reg: ADDR_WIDTH must be within 2..64");
  end

  typedef enum logic {RUN, REPLAY} state_t;

  state_t      state_q, state_nxt;
  logic [63:0] pc_d;
  logic        vld_d;
  logic [31:0] hold_buf;
  logic        capture;
  logic        advance;
  logic [31:0] sel_inst;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    capture   = 1'b0;
    advance   = 1'b0;
    if (flush) begin
      state_nxt = RUN;
    end else if (stall) begin
      if (state_q == RUN) begin
        state_nxt = REPLAY;
        capture   = 1'b1;
      end
    end else begin
      state_nxt = RUN;
      advance   = 1'b1;
    end
    sel_inst = (state_q == REPLAY) ? hold_buf : inst_in;
  end

  // inst_in lags pc_in by one cycle, so it lines up with pc_d, not pc_in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_d      <= '0;
      vld_d     <= 1'b0;
      hold_buf  <= '0;
      pc_out    <= '0;
      inst_out  <= NOP;
      valid_out <= 1'b0;
    end else begin
      if (capture) hold_buf <= inst_in;
      if (flush) begin
        pc_d      <= pc_in;
        vld_d     <= 1'b0;
        inst_out  <= NOP;
        valid_out <= 1'b0;
      end else if (advance) begin
        pc_d      <= pc_in;
        vld_d     <= 1'b1;
        pc_out    <= pc_d;
        inst_out  <= vld_d ? sel_inst : NOP;
        valid_out <= vld_d;
      end
    end
  end

  assign pc_plus4_out   = pc_out + 64'd4;
  assign misaligned_out = valid_out & (pc_out[1:0] != 2'b00);

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: memory model drives inst_in one cycle behind pc_in,
// expected decode outputs queued at fetch time and checked as they emerge.
module tb_if_id_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush;
  logic [63:0] pc_in;
  logic [31:0] inst_in;
  logic [63:0] pc_out, pc_plus4_out;
  logic [31:0] inst_out;
  logic        valid_out, misaligned_out;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [63:0] prev_pc = '0;
  int          n_assert = 0;
  int          n_fail   = 0;

  if_id_reg dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .pc_in(pc_in), .inst_in(inst_in), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .inst_out(inst_out),
    .valid_out(valid_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {8'hC5, a[23:0]} ^ 32'h0055_AA00;
  endfunction

  task automatic drive(input logic s, input logic f, input logic [63:0] pc);
    stall   = s;
    flush   = f;
    pc_in   = pc;
    inst_in = mem(prev_pc);
  endtask

  task automatic fetch(input logic [63:0] pc);
    drive(1'b0, 1'b0, pc);
    sb.push_back('{pc: pc, inst: mem(pc)});
  endtask

  task automatic tick();
    @(posedge clk);
    prev_pc = pc_in;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=no_entry expected=scoreboard_entry", tag);
      return;
    end
    last = sb.pop_front();
    chk({tag, "_valid"}, 64'(valid_out), 64'd1);
    chk({tag, "_pc"}, pc_out, last.pc);
    chk({tag, "_inst"}, 64'(inst_out), 64'(last.inst));
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'd1);
    chk({tag, "_pc"}, pc_out, last.pc);
    chk({tag, "_inst"}, 64'(inst_out), 64'(last.inst));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'd0);
    chk({tag, "_inst"}, 64'(inst_out), 64'(NOP));
    chk({tag, "_mis"}, 64'(misaligned_out), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 64'd0);
    tick();
    drive(1'b1, 1'b1, 64'd0);
    tick();
    chk_bubble("reset");
    chk("reset_pc", pc_out, 64'd0);
    chk("reset_pc4", pc_plus4_out, 64'd4);

    // reset release and straight-line fetch
    reset_n = 1'b1;
    fetch(64'd0);  tick(); chk_bubble("rel_e1"); chk("rel_e1_pc", pc_out, 64'd0);
    fetch(64'd4);  tick(); chk_out("seq0");
    fetch(64'd8);  tick(); chk_out("seq4");

    // three stall cycles; fetch PC holds at 12 while memory moves on
    drive(1'b1, 1'b0, 64'd12); sb.push_back('{pc: 64'd12, inst: mem(64'd12)});
    tick(); chk_hold("stall1");
    drive(1'b1, 1'b0, 64'd12); tick(); chk_hold("stall2");
    drive(1'b1, 1'b0, 64'd12); tick(); chk_hold("stall3");
    drive(1'b0, 1'b0, 64'd12); tick(); chk_out("replay8");
    fetch(64'd16); tick(); chk_out("after12");

    // flush redirect to 0x100
    drive(1'b0, 1'b1, 64'h100); sb.delete();
    tick(); chk_bubble("flush"); chk("flush_pc_hold", pc_out, 64'd12);
    fetch(64'h100); tick(); chk_bubble("flush_e2");
    fetch(64'h104); tick(); chk_out("tgt100");
    fetch(64'h108); tick(); chk_out("tgt104");

    // stall + flush together while in REPLAY
    drive(1'b1, 1'b0, 64'h10C); tick(); chk_hold("rp_stall");
    drive(1'b1, 1'b1, 64'h300); sb.delete();
    tick(); chk_bubble("rp_flush");
    fetch(64'h300); tick(); chk_bubble("rp_flush_e2");
    fetch(64'h304); tick(); chk_out("tgt300");
    fetch(64'h308); tick(); chk_out("tgt304");

    // reset while in REPLAY
    drive(1'b1, 1'b0, 64'h30C); tick(); chk_hold("rst_stall");
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 64'h30C); sb.delete();
    tick(); chk_bubble("rst_rp"); chk("rst_rp_pc", pc_out, 64'd0);
    reset_n = 1'b1;
    fetch(64'd0); tick(); chk_bubble("rel2_e1");
    fetch(64'd4); tick(); chk_out("rel2_0");
    fetch(64'hFFFF_FFFF_FFFF_FFFC); tick(); chk_out("rel2_4");

    // PC wrap and misalignment
    fetch(64'd6);  tick(); chk_out("wrap");
    chk("wrap_pc4", pc_plus4_out, 64'd0);
    chk("wrap_mis", 64'(misaligned_out), 64'd0);
    fetch(64'h10); tick(); chk_out("mis6");
    chk("mis6_flag", 64'(misaligned_out), 64'd1);
    chk("mis6_pc4", pc_plus4_out, 64'hA);
    drive(1'b0, 1'b1, 64'h20); sb.delete();
    tick(); chk_bubble("mis_flush"); chk("mis_flush_pc", pc_out, 64'd6);

    drive(1'b0, 1'b0, 64'd0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
